// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller.
// Holds the controller state encoding, the instruction-memory geometry,
// the opcode field bounds and the opcode value that stops fetching.
package instr_fetch_ctrl_pkg;

  localparam int IM_ADDR_W = 5;
  localparam int IM_DATA_W = 32;

  // Opcode field position inside an instruction word
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;

  localparam logic [OPC_HI-OPC_LO:0] HALT_OPC_DEF = 6'b111111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FILL  = 3'd2,
    ST_FETCH = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

endpackage

// File: rtl/instr_fetch_ctrl_next_pc.sv
// Next fetch address selection.
// Ports:
//   pc_i            current fetch address (address of the instruction on decode)
//   stall_i         decode stall: re-request the current address
//   branch_taken_i  redirect request (loses to stall)
//   branch_target_i redirect address
//   next_pc_o       address to present to the RAM this cycle
module fetch_next_pc #(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              stall_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic [ADDR_W-1:0] next_pc_o
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  always_comb begin
    if (stall_i) begin
      next_pc_o = pc_i;
    end else if (branch_taken_i) begin
      next_pc_o = branch_target_i;
    end else begin
      // Natural overflow of the ADDR_W-bit sum gives the wrap to 0
      next_pc_o = pc_i + ONE;
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the single port of the instruction RAM
// and shares it between a program loader and the fetch engine.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   load_*                program-load interface (load_ready_o/load_done_o out)
//   run_i                 start fetching from RESET_PC (IDLE only)
//   stall_i, branch_*     decode-side flow control and redirect
//   mem_*                 RAM port (we/addr/din out, dout in, 1-cycle read)
//   instr_o, instr_valid_o, pc_out_o  instruction stream to decode
//   halted_o              high while stopped on a halt opcode
//   state_o               current controller state (observability)
//
// Load handshake: a word is accepted in every cycle where load_ready_o and
// load_valid_i are both high; load_ready_o depends only on the state, never
// on load_valid_i, and a word with load_valid_i low is not written.
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter int                 ADDR_W      = IM_ADDR_W,
  parameter int                 DATA_W      = IM_DATA_W,
  parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
  parameter logic [OPC_HI-OPC_LO:0] HALT_OPCODE = HALT_OPC_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_start_i,
  input  logic              load_valid_i,
  input  logic              load_last_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic              load_ready_o,
  output logic              load_done_o,
  input  logic              run_i,
  input  logic              stall_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_din_o,
  input  logic [DATA_W-1:0] mem_dout_i,
  output logic [DATA_W-1:0] instr_o,
  output logic              instr_valid_o,
  output logic [ADDR_W-1:0] pc_out_o,
  output logic              halted_o,
  output state_e            state_o
);

  localparam logic [ADDR_W-1:0] PTR_MAX = '1;
  localparam logic [ADDR_W-1:0] ONE     = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              instr_valid_q, instr_valid_d;
  logic              load_done_q, load_done_d;
  logic [ADDR_W-1:0] req_pc;
  logic              halt_hit;

  fetch_next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc_i            (pc_q),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .next_pc_o       (req_pc)
  );

  // The word on mem_dout_i is the one at pc_q, so the opcode test applies
  // to the instruction currently presented to decode.
  assign halt_hit = instr_valid_q && !stall_i &&
                    (mem_dout_i[OPC_HI:OPC_LO] == HALT_OPCODE);

  always_comb begin
    state_d       = state_q;
    load_ptr_d    = load_ptr_q;
    pc_d          = pc_q;
    instr_valid_d = instr_valid_q;
    load_done_d   = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_din_o     = load_data_i;
    load_ready_o  = 1'b0;
    halted_o      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (load_start_i) begin
          state_d    = ST_LOAD;
          load_ptr_d = '0;
        end else if (run_i) begin
          state_d = ST_FILL;
        end
      end

      ST_LOAD: begin
        load_ready_o = 1'b1;
        mem_we_o     = load_valid_i;
        mem_addr_o   = load_ptr_q;
        if (load_valid_i) begin
          load_ptr_d = load_ptr_q + ONE;
          // Last word either flagged by the loader or forced by full depth
          if (load_last_i || (load_ptr_q == PTR_MAX)) begin
            state_d     = ST_IDLE;
            load_done_d = 1'b1;
          end
        end
      end

      ST_FILL: begin
        mem_addr_o    = RESET_PC;
        pc_d          = RESET_PC;
        instr_valid_d = 1'b1;
        state_d       = ST_FETCH;
      end

      ST_FETCH: begin
        mem_addr_o = req_pc;
        if (halt_hit) begin
          // pc holds the halt address; any branch this cycle is dropped
          state_d       = ST_HALT;
          instr_valid_d = 1'b0;
        end else begin
          pc_d          = req_pc;
          instr_valid_d = 1'b1;
        end
      end

      ST_HALT: begin
        halted_o   = 1'b1;
        mem_addr_o = pc_q;
        if (load_start_i) begin
          state_d    = ST_LOAD;
          load_ptr_d = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      load_ptr_q    <= '0;
      pc_q          <= '0;
      instr_valid_q <= 1'b0;
      load_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_ptr_q    <= load_ptr_d;
      pc_q          <= pc_d;
      instr_valid_q <= instr_valid_d;
      load_done_q   <= load_done_d;
    end
  end

  assign instr_o       = mem_dout_i;
  assign instr_valid_o = instr_valid_q;
  assign pc_out_o      = pc_q;
  assign load_done_o   = load_done_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
module tb_instr_fetch_ctrl;
  import instr_fetch_ctrl_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int SW = AW + DW;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, load_start, load_valid, load_last, run, stall, branch_taken;
  logic [DW-1:0] load_data;
  logic [AW-1:0] branch_target;
  logic          load_ready, load_done, mem_we, instr_valid, halted;
  logic [AW-1:0] mem_addr, pc_out;
  logic [DW-1:0] mem_din, mem_dout, instr;
  state_e        state;

  instr_fetch_ctrl dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .load_start_i    (load_start),
    .load_valid_i    (load_valid),
    .load_last_i     (load_last),
    .load_data_i     (load_data),
    .load_ready_o    (load_ready),
    .load_done_o     (load_done),
    .run_i           (run),
    .stall_i         (stall),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .mem_we_o        (mem_we),
    .mem_addr_o      (mem_addr),
    .mem_din_o       (mem_din),
    .mem_dout_i      (mem_dout),
    .instr_o         (instr),
    .instr_valid_o   (instr_valid),
    .pc_out_o        (pc_out),
    .halted_o        (halted),
    .state_o         (state)
  );

  // Instruction RAM: 1-cycle synchronous read
  logic [DW-1:0] ram [32];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [SW-1:0] exp_q[$];
  logic [DW-1:0] model_mem [32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({a, d});
    model_mem[a] = d;
  endtask

  // Every RAM write must match the next expected {addr, data}
  always @(negedge clk) begin
    logic [SW-1:0] e;
    #2;
    if (mem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ram_write unexpected actual=%0h required=none", {mem_addr, mem_din});
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_din} !== e) begin
          errors++;
          $display("FAIL ram_write actual=%0h required=%0h", {mem_addr, mem_din}, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rs, input logic ls, input logic lv, input logic ll,
                       input logic [DW-1:0] ld, input logic rn, input logic st,
                       input logic br, input logic [AW-1:0] bt);
    @(negedge clk);
    rst = rs; load_start = ls; load_valid = lv; load_last = ll; load_data = ld;
    run = rn; stall = st; branch_taken = br; branch_target = bt;
    #1;
  endtask

  task automatic idle_cycle();
    drive(L, L, L, L, '0, L, L, L, '0);
  endtask

  logic [AW-1:0] exp_pc;

  // One FETCH cycle: check the presented instruction, then advance exp_pc
  task automatic fetch_step(input logic st, input logic br, input logic [AW-1:0] bt);
    drive(L, L, L, L, '0, L, st, br, bt);
    chk("fetch_valid", instr_valid, H);
    chk("fetch_pc", pc_out, exp_pc);
    chk("fetch_instr", instr, model_mem[exp_pc]);
    if (st) exp_pc = exp_pc;
    else if (br) exp_pc = bt;
    else exp_pc = exp_pc + 5'd1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_state"}, state, ST_IDLE);
    chk({tag, "_valid"}, instr_valid, L);
    chk({tag, "_pc"}, pc_out, 5'd0);
    chk({tag, "_done"}, load_done, L);
    chk({tag, "_ready"}, load_ready, L);
    chk({tag, "_halted"}, halted, L);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic ls, lv, ll; logic [DW-1:0] ld; logic rn, st, br; logic [AW-1:0] bt;
    logic e_we, e_chk_addr; logic [AW-1:0] e_addr; logic e_ready, e_done, e_iv;
    logic [AW-1:0] e_pc; logic e_halt, e_chk_instr; logic [DW-1:0] e_instr;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // load 3 words, run, halt on the third (branch in halt cycle ignored)
    //           ls lv ll data            rn st br bt     we ca addr  rdy done iv pc    halt ci instr
    vecs[0]  = '{H, L, L, 32'h0,          L, L, L, 5'd0,  L, H, 5'd0, L, L,   L, 5'd0, L,   L, 32'h0};
    vecs[1]  = '{L, H, L, 32'h00000011,   L, L, L, 5'd0,  H, H, 5'd0, H, L,   L, 5'd0, L,   L, 32'h0};
    vecs[2]  = '{L, H, L, 32'h00000022,   L, L, L, 5'd0,  H, H, 5'd1, H, L,   L, 5'd0, L,   L, 32'h0};
    vecs[3]  = '{L, L, L, 32'h0,          L, L, L, 5'd0,  L, H, 5'd2, H, L,   L, 5'd0, L,   L, 32'h0};
    vecs[4]  = '{L, H, H, 32'hFC000000,   L, L, L, 5'd0,  H, H, 5'd2, H, L,   L, 5'd0, L,   L, 32'h0};
    vecs[5]  = '{L, L, L, 32'h0,          H, L, L, 5'd0,  L, H, 5'd0, L, H,   L, 5'd0, L,   L, 32'h0};
    vecs[6]  = '{L, L, L, 32'h0,          L, L, L, 5'd0,  L, H, 5'd0, L, L,   L, 5'd0, L,   L, 32'h0};
    vecs[7]  = '{L, L, L, 32'h0,          L, L, L, 5'd0,  L, H, 5'd1, L, L,   H, 5'd0, L,   H, 32'h00000011};
    vecs[8]  = '{L, L, L, 32'h0,          L, L, L, 5'd0,  L, H, 5'd2, L, L,   H, 5'd1, L,   H, 32'h00000022};
    vecs[9]  = '{L, L, L, 32'h0,          L, L, H, 5'd7,  L, L, 5'd0, L, L,   H, 5'd2, L,   H, 32'hFC000000};
    vecs[10] = '{L, L, L, 32'h0,          L, L, L, 5'd0,  L, H, 5'd2, L, L,   L, 5'd2, H,   L, 32'h0};
    vecs[11] = '{L, L, L, 32'h0,          H, L, L, 5'd0,  L, H, 5'd2, L, L,   L, 5'd2, H,   L, 32'h0};

    rst = H; load_start = L; load_valid = L; load_last = L; load_data = '0;
    run = L; stall = L; branch_taken = L; branch_target = '0;
    exp_pc = '0;

    // ---- reset ----
    drive(H, L, L, L, '0, L, L, L, '0);
    drive(H, L, L, L, '0, L, L, L, '0);
    idle_cycle();
    check_reset_state("reset");

    // ---- table: load then run to halt ----
    for (int i = 0; i < 12; i++) begin
      drive(L, vecs[i].ls, vecs[i].lv, vecs[i].ll, vecs[i].ld,
            vecs[i].rn, vecs[i].st, vecs[i].br, vecs[i].bt);
      if (vecs[i].e_we) expect_write(vecs[i].e_addr, vecs[i].ld);
      chk($sformatf("v%0d_we", i), mem_we, vecs[i].e_we);
      if (vecs[i].e_chk_addr) chk($sformatf("v%0d_addr", i), mem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_ready", i), load_ready, vecs[i].e_ready);
      chk($sformatf("v%0d_done", i), load_done, vecs[i].e_done);
      chk($sformatf("v%0d_valid", i), instr_valid, vecs[i].e_iv);
      chk($sformatf("v%0d_pc", i), pc_out, vecs[i].e_pc);
      chk($sformatf("v%0d_halted", i), halted, vecs[i].e_halt);
      if (vecs[i].e_chk_instr) chk($sformatf("v%0d_instr", i), instr, vecs[i].e_instr);
    end
    chk("halt_state", state, ST_HALT);

    // ---- full-depth load from HALT, load_last never set ----
    drive(L, H, L, L, '0, L, L, L, '0);
    chk("fl_start_halted", halted, H);
    for (int i = 0; i < 32; i++) begin
      logic [DW-1:0] w;
      w = 32'h00000100 + 32'(i);
      drive(L, L, H, L, w, L, L, L, '0);
      expect_write(5'(i), w);
      chk("fl_ready", load_ready, H);
      chk("fl_done_early", load_done, L);
    end
    idle_cycle();
    chk("fl_exit_state", state, ST_IDLE);
    chk("fl_done_pulse", load_done, H);
    chk("fl_ready_off", load_ready, L);
    idle_cycle();
    chk("fl_done_once", load_done, L);

    // ---- run: sequential, stall+branch, branch, wrap, stall ----
    drive(L, L, L, L, '0, H, L, L, '0);
    idle_cycle();
    chk("fill_state", state, ST_FILL);
    chk("fill_addr", mem_addr, 5'd0);
    exp_pc = 5'd0;
    for (int k = 0; k < 3; k++) fetch_step(L, L, '0);   // pc 0,1,2
    fetch_step(H, H, 5'd20);                             // pc 3, stall wins
    fetch_step(L, H, 5'd20);                             // pc 3 again, branch
    for (int k = 0; k < 16; k++) fetch_step(L, L, '0);  // pc 20..31,0..3
    for (int k = 0; k < 3; k++) fetch_step(H, L, '0);   // pc 4 held
    fetch_step(L, L, '0);                                // pc 4, released
    fetch_step(L, L, '0);                                // pc 5
    chk("resume_pc5_seen", exp_pc, 5'd6);

    // ---- reset during FETCH ----
    drive(H, L, L, L, '0, L, L, L, '0);
    idle_cycle();
    check_reset_state("rst_fetch");

    // ---- reset mid-load; load_start wins over run in IDLE ----
    drive(L, H, L, L, '0, H, L, L, '0);
    drive(L, L, H, L, 32'h0000AAA0, L, L, L, '0);
    expect_write(5'd0, 32'h0000AAA0);
    chk("ml_ready", load_ready, H);
    drive(L, L, H, L, 32'h0000AAA1, L, L, L, '0);
    expect_write(5'd1, 32'h0000AAA1);
    drive(H, L, L, L, '0, L, L, L, '0);
    idle_cycle();
    chk("ml_state", state, ST_IDLE);
    chk("ml_ready_off", load_ready, L);
    chk("ml_no_done", load_done, L);
    idle_cycle();
    chk("ml_no_done2", load_done, L);
    drive(L, L, L, L, '0, H, L, L, '0);
    idle_cycle();
    exp_pc = 5'd0;
    for (int k = 0; k < 3; k++) fetch_step(L, L, '0);   // AAA0, AAA1, old word 2

    idle_cycle();
    chk("writes_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Sequences the single-port instruction memory block RAM (5-bit address, 32-bit data, 1-cycle synchronous read). It owns the RAM port and shares it between two users: a program loader that writes words during LOAD, and a fetch engine that streams instructions to decode. The fetch engine handles stall, branch redirect and halt. It sits between the program-load interface, the IM RAM and the decode stage of the RISC core.

Parameters:
ADDR_W, 5, instruction address width; memory depth is 2**ADDR_W.
DATA_W, 32, instruction width.
RESET_PC, 0, first fetch address after run.
HALT_OPCODE, 6'b111111, value of instr[31:26] that halts fetch.

Ports:
clk  input  1  system clock; all state updates on posedge.
rst  input  1  synchronous, active-high reset.
load_start  input  1  enter LOAD; honoured only in IDLE or HALT.
load_valid  input  1  load_data is valid this cycle.
load_last  input  1  qualifies load_valid; marks the final word.
load_data  input  DATA_W  word to write.
load_ready  output  1  high in LOAD, combinational from state.
load_done  output  1  one-cycle pulse when LOAD completes.
run  input  1  start fetching; honoured only in IDLE.
stall  input  1  decode stall; hold the current instruction.
branch_taken  input  1  redirect fetch; ignored while stall=1.
branch_target  input  ADDR_W  redirect address.
mem_we  output  1  RAM write enable (combinational).
mem_addr  output  ADDR_W  RAM address (combinational).
mem_din  output  DATA_W  RAM write data (combinational).
mem_dout  input  DATA_W  RAM read data, valid the cycle after the address is sampled.
instr  output  DATA_W  equals mem_dout.
instr_valid  output  1  instr/pc_out are valid (registered).
pc_out  output  ADDR_W  address of instr (registered).
halted  output  1  high in HALT.

Behaviour:
- States: IDLE, LOAD, FILL, FETCH, HALT. Reset to IDLE.
- Reset values: load_ptr=0, pc_out=0, instr_valid=0, load_done=0. halted=0 and load_ready=0 follow from IDLE.
- Reset mid-operation returns to IDLE next cycle. RAM contents already written are retained.
- Priority in IDLE: load_start beats run. load_start in FILL or FETCH is ignored.
- IDLE: mem_we=0, mem_addr=0.
  - load_start -> LOAD with load_ptr=0.
  - else run -> FILL.
- LOAD: mem_we=load_valid, mem_addr=load_ptr, mem_din=load_data.
  - Each accepted word increments load_ptr (modulo depth).
  - Leave LOAD -> IDLE, with load_done pulsed the following cycle, when an accepted word has load_last=1 or load_ptr==2**ADDR_W-1.
  - load_valid=0 cycles write nothing.
- FILL (one cycle): mem_addr=RESET_PC, mem_we=0.
  - Registers pc_out<=RESET_PC, instr_valid<=1 next cycle -> FETCH.
- FETCH: mem_we=0. Requested address is decided with priority stall > branch_taken > sequential:
  - stall=1: req=pc_out.
  - branch_taken=1: req=branch_target.
  - otherwise: req=pc_out+1, wrapping 31->0.
  - mem_addr=req; at posedge pc_out<=req, instr_valid<=1.
  - Stalling re-reads the same address, so instr stays stable. Branch redirect has zero bubble.
- Halt: in FETCH with instr_valid=1, stall=0 and instr[31:26]==HALT_OPCODE -> HALT.
  - instr_valid<=0; pc_out holds the halt address.
  - A branch in that same cycle is ignored.
- HALT: halted=1, mem_addr=pc_out, mem_we=0.
  - Exit only via rst, or load_start -> LOAD.
- No read and write to the RAM in the same cycle; the state machine guarantees this.

Decomposition:
- Shared package: state encoding (IDLE/LOAD/FILL/FETCH/HALT), HALT_OPCODE, opcode field bounds [31:26], IM address width.
- A sub-module is natural for the next-address mux (stall/branch/increment with wrap): fetch_next_pc.
- The state machine and the load pointer stay in the top module.

Test Plan:
- Load then run: load_start, then 3 words 0x00000011, 0x00000022 and 0xFC000000 (last). Expect mem_we on addresses 0,1,2 and load_done one cycle after the last word. Then run: instr_valid sequence pc 0,1,2 with instr matching; halt at pc 2, halted=1, instr_valid=0.
- Stall: during FETCH at pc_out=4, hold stall for 3 cycles. pc_out stays 4 and instr stays unchanged; fetch resumes at 5.
- Branch: at pc_out=3 pulse branch_taken, target=20. The next cycle has pc_out=20 and instr_valid=1 with no bubble. stall and branch together: pc_out holds 3.
- Wrap: fill the RAM with non-halt words and run from 0. pc_out goes 31 -> 0 continuously.
- Reset mid-load: assert rst after 2 of 5 words. Expect IDLE, load_ready=0, no load_done. The words at 0 and 1 are retained (verify by a subsequent run).
- Load full depth: 32 words with load_last=0 throughout. LOAD exits after word 31 and load_done pulses once.
